// File: rtl/_riscv_defines.sv
// Core-wide widths and the memory access size encoding shared by the LSU and dcache.
package _riscv_defines;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_read_size_t;
endpackage

// File: rtl/dcache_if.sv
// Word-addressed dcache port: one request held until resp_valid, whole-word writes only.
interface dcache_if;
  import _riscv_defines::*;

  logic                  req_valid;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  mem_read_size_t        size;
  logic                  sign;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output req_valid, write_en, addr, write_data, size, sign,
    input  resp_valid, read_data
  );

  modport slave (
    input  req_valid, write_en, addr, write_data, size, sign,
    output resp_valid, read_data
  );
endinterface

// File: rtl/lsu_dcache_master.sv
// MEM-stage load/store unit: alignment check, sub-word load extraction and RMW sub-word stores.
// All outputs, including the dcache port, are registered from the next state.
module lsu_dcache_master
  import _riscv_defines::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  mem_read_size_t        req_size,
  input  logic                  req_sign,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  dcache_if.master              dcache_if
);

  typedef enum logic [2:0] {
    IDLE, FAULT, ACCESS, RMW_RD, RMW_GAP, RMW_WR, DONE
  } state_t;

  state_t state, state_nxt;

  logic        accept;
  logic        misaligned;
  logic        sub_word_store;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merged;

  logic                  req_ready_nxt;
  logic                  resp_valid_nxt;
  logic                  resp_mis_nxt;
  logic [DATA_WIDTH-1:0] resp_rdata_nxt;
  logic                  dc_req_nxt;
  logic                  dc_we_nxt;
  logic [ADDR_WIDTH-1:0] dc_addr_nxt;
  logic [DATA_WIDTH-1:0] dc_wdata_nxt;
  mem_read_size_t        dc_size_nxt;
  logic                  dc_sign_nxt;

  assign accept         = req_valid && (state == IDLE);
  assign sub_word_store = req_write && (req_size == SIZE_BYTE || req_size == SIZE_HALF);

  always_comb begin
    case (req_size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = req_addr[0];
      default:   misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)          state_nxt = FAULT;
          else if (sub_word_store) state_nxt = RMW_RD;
          else                     state_nxt = ACCESS;
        end
      end
      FAULT:   state_nxt = IDLE;
      ACCESS:  if (dcache_if.resp_valid) state_nxt = DONE;
      RMW_RD:  if (dcache_if.resp_valid) state_nxt = RMW_GAP;
      RMW_GAP: state_nxt = RMW_WR;
      RMW_WR:  if (dcache_if.resp_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Size and sign of the in-flight request live in the registered dcache outputs.
  always_comb begin
    case (lat_off)
      2'd0:    ld_byte = dcache_if.read_data[7:0];
      2'd1:    ld_byte = dcache_if.read_data[15:8];
      2'd2:    ld_byte = dcache_if.read_data[23:16];
      default: ld_byte = dcache_if.read_data[31:24];
    endcase
    ld_half = lat_off[1] ? dcache_if.read_data[31:16] : dcache_if.read_data[15:0];
    case (dcache_if.size)
      SIZE_BYTE: load_val = {{24{dcache_if.sign & ld_byte[7]}}, ld_byte};
      SIZE_HALF: load_val = {{16{dcache_if.sign & ld_half[15]}}, ld_half};
      default:   load_val = dcache_if.read_data;
    endcase
  end

  always_comb begin
    merged = dcache_if.read_data;
    if (dcache_if.size == SIZE_BYTE) begin
      case (lat_off)
        2'd0:    merged[7:0]   = lat_wdata[7:0];
        2'd1:    merged[15:8]  = lat_wdata[7:0];
        2'd2:    merged[23:16] = lat_wdata[7:0];
        default: merged[31:24] = lat_wdata[7:0];
      endcase
    end else if (lat_off[1]) begin
      merged[31:16] = lat_wdata;
    end else begin
      merged[15:0] = lat_wdata;
    end
  end

  always_comb begin
    req_ready_nxt  = (state_nxt == IDLE);
    resp_valid_nxt = (state_nxt == DONE) || (state_nxt == FAULT);
    resp_mis_nxt   = (state_nxt == FAULT);
    dc_req_nxt     = (state_nxt == ACCESS) || (state_nxt == RMW_RD) || (state_nxt == RMW_WR);
    dc_we_nxt      = (state_nxt == RMW_WR) ||
                     ((state_nxt == ACCESS) && (accept ? req_write : dcache_if.write_en));
    resp_rdata_nxt = resp_rdata;
    dc_addr_nxt    = dcache_if.addr;
    dc_wdata_nxt   = dcache_if.write_data;
    dc_size_nxt    = dcache_if.size;
    dc_sign_nxt    = dcache_if.sign;
    if (accept) begin
      dc_addr_nxt  = {2'b00, req_addr[ADDR_WIDTH-1:2]};
      dc_wdata_nxt = req_wdata;
      dc_size_nxt  = req_size;
      dc_sign_nxt  = req_sign;
    end
    if (state_nxt == FAULT) resp_rdata_nxt = '0;
    if (state == ACCESS && dcache_if.resp_valid)
      resp_rdata_nxt = dcache_if.write_en ? '0 : load_val;
    if (state == RMW_RD && dcache_if.resp_valid) dc_wdata_nxt = merged;
    if (state == RMW_WR && dcache_if.resp_valid) resp_rdata_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready            <= 1'b1;
      resp_valid           <= 1'b0;
      resp_misaligned      <= 1'b0;
      resp_rdata           <= '0;
      dcache_if.req_valid  <= 1'b0;
      dcache_if.write_en   <= 1'b0;
      dcache_if.addr       <= '0;
      dcache_if.write_data <= '0;
      dcache_if.size       <= SIZE_BYTE;
      dcache_if.sign       <= 1'b0;
      lat_off              <= 2'b00;
      lat_wdata            <= '0;
    end else begin
      req_ready            <= req_ready_nxt;
      resp_valid           <= resp_valid_nxt;
      resp_misaligned      <= resp_mis_nxt;
      resp_rdata           <= resp_rdata_nxt;
      dcache_if.req_valid  <= dc_req_nxt;
      dcache_if.write_en   <= dc_we_nxt;
      dcache_if.addr       <= dc_addr_nxt;
      dcache_if.write_data <= dc_wdata_nxt;
      dcache_if.size       <= dc_size_nxt;
      dcache_if.sign       <= dc_sign_nxt;
      if (accept) begin
        lat_off   <= req_addr[1:0];
        lat_wdata <= req_wdata[15:0];
      end
    end
  end

endmodule

// File: doc/lsu_dcache_master.md
Name: lsu_dcache_master

Overview:
- Load/store unit for the MEM stage. It is the initiator side of the dcache interface and drives the interface's master modport.
- Accepts one pipeline memory request at a time and checks its alignment.
- Converts the byte address to a word index for the cache.
- Extracts and sign-extends sub-word load data from the returned word.
- Performs sub-word stores as read-modify-write, because the cache writes whole words only.
- Deasserts the cache request between transactions so the cache's latency counter can reload.

Parameters:
- None. Widths come from _riscv_defines: ADDR_WIDTH = 32 and DATA_WIDTH = 32.
- Size encoding uses mem_read_size_t, with byte, half and word values.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  pipeline request strobe.
- req_ready  output  1  high in IDLE; a request is accepted when req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_size  input  mem_read_size_t  access size.
- req_sign  input  1  1 = sign-extend a load.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result; 0 for stores and faults.
- resp_misaligned  output  1  qualifies resp_valid; marks an alignment fault.
- dcache_if  interface  dcache_if.master  cache port.

Behaviour:
- Reset: all outputs are asynchronous to reset.
  - state = IDLE, req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, resp_misaligned = 0.
  - dcache_if.req_valid = 0 and dcache_if.write_en = 0.
  - dcache_if.addr, write_data, size and sign are all 0.
- Accept: on acceptance, latch write, addr, wdata, size and sign. Ignore req_valid outside IDLE.
- Alignment:
  - half: fault if addr[0] = 1.
  - word: fault if addr[1:0] != 0.
  - On a fault, go to FAULT with no cache traffic. Next cycle: resp_valid = 1, resp_misaligned = 1, resp_rdata = 0; then return to IDLE.
- Cache address: dcache_if.addr = {2'b00, addr[31:2]}. size and sign pass through from the latched request.
- All dcache_if outputs are registered (driven from state and latched fields).
- States: IDLE, FAULT, ACCESS, RMW_RD, RMW_GAP, RMW_WR, DONE.
  - IDLE to ACCESS: accepted load or word store.
  - IDLE to RMW_RD: accepted byte or half store.
  - ACCESS: req_valid = 1; write_en = 1 for a store; write_data = wdata. Stay until dcache_if.resp_valid, then go to DONE.
  - RMW_RD: req_valid = 1, write_en = 0. On resp_valid, merge into the latched word and go to RMW_GAP.
    - byte merge: replace bits [8*addr[1:0] +: 8] with wdata[7:0].
    - half merge: replace bits [16*addr[1] +: 16] with wdata[15:0].
  - RMW_GAP: req_valid = 0 for exactly one cycle, then go to RMW_WR.
  - RMW_WR: req_valid = 1, write_en = 1, write_data = merged word. On resp_valid go to DONE.
  - DONE: req_valid = 0; resp_valid = 1 for one cycle; then go to IDLE. req_ready is still 0 in DONE.
- Load extraction: capture dcache_if.read_data in the cycle resp_valid is high.
  - byte: lane = addr[1:0].
  - half: lane = addr[1].
  - Sign-extend when sign = 1, zero-extend when sign = 0. word passes through unchanged.
  - The result is registered into resp_rdata, presented in DONE, and held until the next response.
- Request gap: dcache_if.req_valid is low for at least one cycle between any two cache transactions, guaranteed by RMW_GAP, DONE and IDLE.
- Late deassert: the cache request stays high in the cycle the cache returns resp_valid and drops the following cycle. This is legal; writes are idempotent.
- Latency: with cache delay D, each cache transaction takes D+1 cycles from the first req_valid cycle to dcache resp_valid. With D = 4:
  - load or word store: resp_valid 7 cycles after the acceptance edge.
  - sub-word store: resp_valid 14 cycles after the acceptance edge.
- Reset mid-operation: return to IDLE immediately and drop dcache req_valid asynchronously. No response is issued. A partially completed RMW leaves memory unmodified unless RMW_WR was reached.

Test Plan:
- Word store 0xDEADBEEF to 0x100, then word load from 0x100 -> dcache addr 0x40; load resp_rdata = 0xDEADBEEF 7 cycles after acceptance; req_valid low between the two transactions.
- Word 0x80FF7F01 at 0x200. lb 0x203 signed -> 0xFFFFFF80; lbu 0x201 -> 0x0000007F; lh 0x202 signed -> 0xFFFF80FF; lhu 0x200 -> 0x00007F01.
- Word 0x11223344 at 0x300, then sb 0xAA to 0x301 -> RMW; word load returns 0x1122AA44; store resp at cycle 14; one-cycle gap observed.
- lw 0x102, lh 0x101 and sw 0x103 -> each gives resp_valid with misaligned = 1 and rdata = 0 the next cycle; dcache req_valid never asserts.
- Assert rst_n = 0 in the third cycle of an ACCESS load -> dcache req_valid drops the same cycle; no resp_valid; req_ready = 1 after release.
- Hold req_valid high through a transaction -> exactly one accept per IDLE visit; second request accepted only after the DONE cycle.
